fifo_stream_reader: RTL and testbench

Read-side adapter that drains a `sync_fifo` read port (registered read, one-cycle `dout` latency) and presents the words as a valid/ready stream with full throughput. It sits between a buffering FIFO and any downstream consumer that applies backpressure. It hides the FIFO read latency with a 2-entry output buffer, and frames the stream into fixed-length packets via `m_last`.

---
 rtl/fifo_stream_reader_pkg.sv | 6 +
 rtl/stream_buf2.sv | 41 ++++
 rtl/fifo_stream_reader.sv | 50 +++++
 tb/tb_fifo_stream_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared sizing helper for the stream reader.
package fifo_stream_reader_pkg;
    function automatic int cnt_width(input int pkt_len);
        return (pkt_len < 2) ? 1 : $clog2(pkt_len);
    endfunction
endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry register FIFO; head is always a register so the output never sees push_data combinationally.
module stream_buf2 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            level,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] tail;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (level == 2'd0) head <= push_data;
                    else tail <= push_data;
                    level <= level + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    level <= level - 2'd1;
                end
                2'b11: begin
                    if (level == 2'd1) head <= push_data;
                    else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read FIFO into a valid/ready stream framed by m_last.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            buf_level
);
    localparam int CW = cnt_width(PKT_LEN);
    localparam logic [CW-1:0] LAST = CW'((PKT_LEN > 0) ? PKT_LEN - 1 : 0);
    logic [1:0]    level;
    logic          inflight;
    logic          pop;
    logic [CW-1:0] count;
    stream_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (fifo_dout),
        .pop       (pop),
        .level     (level),
        .head      (m_data)
    );
    assign buf_level = level;
    assign m_valid   = level != 2'd0;
    assign pop       = m_valid && m_ready;
    // Count the in-flight word as already buffered so the buffer can never overflow.
    assign fifo_rd_en = rst_n && !fifo_empty &&
                        (({1'b0, level} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    assign m_last = (PKT_LEN != 0) && m_valid && (count == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop && PKT_LEN != 0) count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized scoreboard bench against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] fifo_dout = '0;
    logic       fifo_empty = 1'b0;
    logic       m_ready = 1'b0;
    logic       fifo_rd_en, m_valid, m_last;
    logic [7:0] m_data;
    logic [1:0] buf_level;
    logic       u0_rd, u0_valid, u0_last, u1_rd, u1_valid, u1_last;
    logic [7:0] u0_data, u1_data;
    logic [1:0] u0_level, u1_level;

    int pass_cnt = 0;
    int total_cnt = 0;
    int nviol = 0;
    int cyc = 0;
    int beat_no = 0;
    logic rd_s, beat_s, valid_s, gap;
    logic [7:0] q[$];
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(16)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .buf_level(buf_level));
    fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(u0_rd), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(u0_valid), .m_ready(m_ready), .m_data(u0_data),
        .m_last(u0_last), .buf_level(u0_level));
    fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .fifo_rd_en(u1_rd), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .m_valid(u1_valid), .m_ready(m_ready), .m_data(u1_data),
        .m_last(u1_last), .buf_level(u1_level));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic load(input int n, input logic [7:0] base, input logic rnd);
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            w = rnd ? 8'($urandom) : base + 8'(i);
            q.push_back(w);
            sb.push_back(w);
        end
    endtask

    // One clock of the sync_fifo model: inputs set at negedge, rd_en sampled before the edge,
    // read data presented just after the edge.
    task automatic step(input logic rdy, input logic gp);
        @(negedge clk);
        gap = gp;
        m_ready = rdy;
        fifo_empty = gap || q.size() == 0;
        #1;
        rd_s = fifo_rd_en;
        valid_s = m_valid;
        beat_s = m_valid && m_ready;
        if (fifo_empty && rd_s) nviol++;
        if (buf_level > 2'd2) nviol++;
        cyc++;
        @(posedge clk);
        #1;
        if (rd_s && rst_n) begin
            if (q.size() == 0) nviol++;
            else fifo_dout = q.pop_front();
        end
        fifo_empty = gap || q.size() == 0;
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb.size() > 0 && n < limit) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (4) step(1'b1, 1'b0);
    endtask

    // Monitor: compares every transferred beat against the scoreboard and the framing rule.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) beat_no = 0;
        else if (m_valid && m_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
            else begin
                chk("beat_data", m_data, sb.pop_front());
                chk("last_pkt16", m_last, (beat_no % 16) == 15);
                chk("last_pkt0", u0_last, 0);
                chk("last_pkt1", u1_last, 1);
                beat_no++;
            end
        end
    end

    initial begin
        int t0, n, beats;
        logic [7:0] d0;
        gap = 1'b0;
        rst_n = 1'b0;
        fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_level", buf_level, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        fifo_empty = 1'b1;
        rst_n = 1'b1;

        load(16, 8'h00, 1'b0);
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (!rd_s && n < 20);
        t0 = cyc;
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (!valid_s && n < 20);
        chk("first_latency", cyc - t0, 2);
        beats = beat_s ? 1 : 0;
        repeat (15) begin step(1'b1, 1'b0); if (beat_s) beats++; end
        chk("burst_no_gaps", beats, 16);
        drain("burst_drain", 50);

        load(8, 8'h20, 1'b0);
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (!beat_s && n < 20);
        step(1'b0, 1'b0);
        d0 = m_data;
        repeat (5) step(1'b0, 1'b0);
        chk("bp_level", buf_level, 2);
        chk("bp_rd_en", rd_s, 0);
        chk("bp_valid", m_valid, 1);
        chk("bp_data_stable", m_data, d0);
        drain("bp_drain", 50);

        n = 0;
        for (int issued = 0; (issued < 1024 || sb.size() > 0) && n < 20000; n++) begin
            if (issued < 1024 && $urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(1, 3);
                if (k > 1024 - issued) k = 1024 - issued;
                load(k, 8'h00, 1'b1);
                issued += k;
            end
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
        chk("soak_drain", sb.size(), 0);
        chk("soak_protocol", nviol, 0);

        load(10, 8'h50, 1'b0);
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (!beat_s && n < 20);
        repeat (4) step(1'b0, 1'b0);
        chk("pre_reset_level", buf_level, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_level", buf_level, 0);
        chk("async_rst_rd_en", fifo_rd_en, 0);
        q.delete();
        sb.delete();
        fifo_dout = '0;
        repeat (2) step(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        load(16, 8'hA0, 1'b0);
        drain("post_reset_drain", 60);
        chk("final_protocol", nviol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
